// File: rtl/sum_buf_pkg.sv
// ============================================================================
// Module  : sum_buf_pkg
// Purpose : Shared defaults and helpers for the sum result buffer.
//           SUM_W     - result data width (matches the upstream adder)
//           SUM_DEPTH - FIFO entries (power of two, >= 2)
//           SUM_CNT_W - saturating drop-counter width (1..32)
//           sat_inc() - increment that holds at the all-ones value of a width
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package sum_buf_pkg;

  localparam int SUM_W     = 8;
  localparam int SUM_DEPTH = 4;
  localparam int SUM_CNT_W = 8;

  // Returns value+1, or value unchanged when it already equals the all-ones
  // pattern of 'width' bits. Widths above 32 are not supported.
  function automatic logic [31:0] sat_inc(input logic [31:0] value,
                                          input int unsigned width);
    logic [31:0] all_ones;
    all_ones = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    return (value == all_ones) ? value : (value + 32'd1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/sum_buf_mem.sv
// ============================================================================
// Module  : sum_buf_mem
// Purpose : DEPTH x W register array, one synchronous write port and one
//           combinational read port. Storage is intentionally not reset.
// Ports   : clk   - rising-edge clock
//           we    - write enable
//           waddr - write address
//           wdata - write data
//           raddr - read address
//           rdata - read data (combinational from the array)
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module sum_buf_mem
  import sum_buf_pkg::*;
#(
  parameter int W     = SUM_W,
  parameter int DEPTH = SUM_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

`default_nettype wire

// File: rtl/sum_result_buffer.sv
// ============================================================================
// Module  : sum_result_buffer
// Purpose : Captures one-cycle (valid, data) result pulses from the adder into
//           a first-word-fall-through FIFO and presents them over valid/ready.
//           The producer cannot be stalled, so pulses arriving while full (and
//           not freed by a same-cycle pop) are dropped, counted and flagged.
// Ports   : clk       - rising-edge clock
//           rst_n     - synchronous active-low reset
//           in_valid  - result pulse from the adder
//           in_data   - result data from the adder
//           out_valid - head entry available
//           out_ready - consumer accepts the head entry this cycle
//           out_data  - head entry data (don't-care while out_valid == 0)
//           count     - number of entries held
//           full      - count == DEPTH
//           empty     - count == 0
//           drop_cnt  - saturating count of dropped results
//           overflow  - sticky flag, set by the first drop
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module sum_result_buffer
  import sum_buf_pkg::*;
#(
  parameter int W     = SUM_W,
  parameter int DEPTH = SUM_DEPTH,
  parameter int CNT_W = SUM_CNT_W
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  input  logic [W-1:0]               in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [W-1:0]               out_data,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty,
  output logic [CNT_W-1:0]           drop_cnt,
  output logic                       overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
  logic             overflow_q, overflow_d;

  logic w_full;
  logic w_empty;
  logic w_pop;
  logic w_push;
  logic w_drop;

  assign w_full  = (count_q == CW'(DEPTH));
  assign w_empty = (count_q == '0);

  // A pop in the same cycle frees the slot the incoming pulse needs, so a
  // full buffer still accepts a result when the consumer is draining.
  assign w_pop  = !w_empty && out_ready;
  assign w_push = in_valid && (!w_full || w_pop);
  assign w_drop = in_valid && w_full && !w_pop;

  sum_buf_mem #(
    .W     (W),
    .DEPTH (DEPTH),
    .AW    (PW)
  ) u_mem (
    .clk   (clk),
    .we    (w_push),
    .waddr (wr_ptr_q),
    .wdata (in_data),
    .raddr (rd_ptr_q),
    .rdata (out_data)
  );

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    drop_cnt_d = drop_cnt_q;
    overflow_d = overflow_q;

    // DEPTH is a power of two, so natural pointer overflow wraps modulo DEPTH.
    if (w_push) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (w_pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end

    case ({w_push, w_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    if (w_drop) begin
      drop_cnt_d = CNT_W'(sat_inc(32'(drop_cnt_q), CNT_W));
      overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      drop_cnt_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      drop_cnt_q <= drop_cnt_d;
      overflow_q <= overflow_d;
    end
  end

  assign out_valid = !w_empty;
  assign count     = count_q;
  assign full      = w_full;
  assign empty     = w_empty;
  assign drop_cnt  = drop_cnt_q;
  assign overflow  = overflow_q;

endmodule

`default_nettype wire

// File: tb/tb_sum_result_buffer.sv
// ============================================================================
// Module  : tb_sum_result_buffer
// Purpose : Self-checking bench for sum_result_buffer. A queue-based model of
//           the buffer is compared with two DUT instances (CNT_W=8 and
//           CNT_W=2) on every falling edge, plus literal checks per scenario.
//           The upstream adder is represented by driving (a+b) mod 2^W pulses.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sum_result_buffer;

  localparam int W     = 8;
  localparam int DEPTH = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic [W-1:0] in_data;
  logic         out_ready;

  logic         out_valid, full, empty, overflow;
  logic [W-1:0] out_data;
  logic [2:0]   count;
  logic [7:0]   drop_cnt;

  logic         out_valid2, full2, empty2, overflow2;
  logic [W-1:0] out_data2;
  logic [2:0]   count2;
  logic [1:0]   drop_cnt2;

  always #5 clk = ~clk;

  sum_result_buffer #(.W(W), .DEPTH(DEPTH), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .count(count), .full(full), .empty(empty), .drop_cnt(drop_cnt),
    .overflow(overflow)
  );

  sum_result_buffer #(.W(W), .DEPTH(DEPTH), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .out_valid(out_valid2), .out_ready(out_ready), .out_data(out_data2),
    .count(count2), .full(full2), .empty(empty2), .drop_cnt(drop_cnt2),
    .overflow(overflow2)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [W-1:0] mq[$];
  int           m_drops = 0;
  bit           m_ovf   = 0;

  always @(posedge clk) begin
    if (!rst_n) begin
      mq.delete();
      m_drops = 0;
      m_ovf   = 0;
    end else begin
      bit was_full, popped;
      was_full = (mq.size() == DEPTH);
      popped   = (mq.size() != 0) && out_ready;
      if (popped) void'(mq.pop_front());
      if (in_valid) begin
        if (!was_full || popped) mq.push_back(in_data);
        else begin
          m_drops++;
          m_ovf = 1;
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  bit           chk_en  = 0;
  bit           wrap_on = 0;
  bit           e2e_on  = 0;
  logic [W-1:0] e2e_q[$];
  int           e2e_pops = 0;

  always @(negedge clk) begin
    if (chk_en) begin
      int sz;
      sz = mq.size();
      chk("m_out_valid", 32'(out_valid), 32'(sz != 0));
      chk("m_count",     32'(count),     32'(sz));
      chk("m_full",      32'(full),      32'(sz == DEPTH));
      chk("m_empty",     32'(empty),     32'(sz == 0));
      chk("m_drop_cnt",  32'(drop_cnt),  (m_drops > 255) ? 32'd255 : 32'(m_drops));
      chk("m_overflow",  32'(overflow),  32'(m_ovf));
      chk("m2_count",    32'(count2),    32'(sz));
      chk("m2_drop_cnt", 32'(drop_cnt2), (m_drops > 3) ? 32'd3 : 32'(m_drops));
      chk("m2_overflow", 32'(overflow2), 32'(m_ovf));
      if (sz != 0) begin
        chk("m_out_data",  32'(out_data),  32'(mq[0]));
        chk("m2_out_data", 32'(out_data2), 32'(mq[0]));
      end
      if (wrap_on) begin
        chk("wrap_count_le1", 32'(count <= 3'd1), 32'd1);
      end
      if (e2e_on && out_valid && out_ready) begin
        if (e2e_q.size() == 0) chk("e2e_unexpected_pop", 32'd1, 32'd0);
        else begin
          chk("e2e_sum", 32'(out_data), 32'(e2e_q.pop_front()));
          e2e_pops++;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  // One-cycle pulse; caller is just after a rising edge.
  task automatic push(input logic [W-1:0] d, input logic rdy);
    in_valid  = 1'b1;
    in_data   = d;
    out_ready = rdy;
    sync();
    in_valid  = 1'b0;
    out_ready = 1'b0;
  endtask

  // Check head at falling edge, then accept it on the next edge.
  task automatic pop_expect(input string name, input logic [W-1:0] d);
    @(negedge clk);
    chk({name, "_valid"}, 32'(out_valid), 32'd1);
    chk({name, "_data"},  32'(out_data),  32'(d));
    sync();
    out_ready = 1'b1;
    sync();
    out_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

    // 1. reset
    repeat (3) sync();
    chk_en = 1;
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_count",     32'(count),     32'd0);
    chk("rst_empty",     32'(empty),     32'd1);
    chk("rst_full",      32'(full),      32'd0);
    chk("rst_drop_cnt",  32'(drop_cnt),  32'd0);
    chk("rst_overflow",  32'(overflow),  32'd0);
    sync();
    rst_n = 1'b1;
    sync();

    // 2. single push, held
    push(8'h2A, 1'b0);
    @(negedge clk);
    chk("hold_valid", 32'(out_valid), 32'd1);
    chk("hold_data",  32'(out_data),  32'h2A);
    chk("hold_count", 32'(count),     32'd1);
    repeat (5) begin
      sync();
      @(negedge clk);
      chk("hold_stable_valid", 32'(out_valid), 32'd1);
      chk("hold_stable_data",  32'(out_data),  32'h2A);
    end
    sync();
    out_ready = 1'b1;
    sync();
    out_ready = 1'b0;
    @(negedge clk);
    chk("hold_empty_after", 32'(empty), 32'd1);

    // 3. fill, drop, saturate, drain
    sync();
    for (int i = 1; i <= 4; i++) push(W'(i), 1'b0);
    @(negedge clk);
    chk("fill_full", 32'(full), 32'd1);
    sync();
    push(8'h05, 1'b0);
    @(negedge clk);
    chk("drop_cnt_1",    32'(drop_cnt), 32'd1);
    chk("drop_overflow", 32'(overflow), 32'd1);
    chk("drop_head",     32'(out_data), 32'h01);
    chk("drop_count",    32'(count),    32'd4);
    sync();
    repeat (4) push(8'h06, 1'b0);
    @(negedge clk);
    chk("drop_cnt_5",     32'(drop_cnt),  32'd5);
    chk("drop_cnt2_sat",  32'(drop_cnt2), 32'd3);
    sync();
    for (int i = 1; i <= 4; i++) pop_expect("drain", W'(i));
    @(negedge clk);
    chk("drain_empty", 32'(empty), 32'd1);

    // 4. full with simultaneous push+pop
    sync();
    for (int i = 1; i <= 4; i++) push(W'(i), 1'b0);
    push(8'h09, 1'b1);
    @(negedge clk);
    chk("pp_count",    32'(count),    32'd4);
    chk("pp_drop_cnt", 32'(drop_cnt), 32'd5);
    chk("pp_head",     32'(out_data), 32'h02);
    sync();
    pop_expect("pp_drain", 8'h02);
    pop_expect("pp_drain", 8'h03);
    pop_expect("pp_drain", 8'h04);
    pop_expect("pp_drain", 8'h09);
    @(negedge clk);
    chk("pp_empty", 32'(empty), 32'd1);

    // 5. wrap-around with continuous consumer
    sync();
    wrap_on = 1;
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      in_data  = W'(8'h10 + i);
      sync();
      in_valid = 1'b0;
      sync();
    end
    out_ready = 1'b0;
    sync();
    wrap_on = 0;
    @(negedge clk);
    chk("wrap_drop_cnt", 32'(drop_cnt), 32'd5);
    chk("wrap_empty",    32'(empty),    32'd1);

    // 6. reset mid-operation
    sync();
    push(8'hA1, 1'b0);
    push(8'hA2, 1'b0);
    push(8'hA3, 1'b0);
    @(negedge clk);
    chk("mid_count3", 32'(count), 32'd3);
    sync();
    rst_n = 1'b0;
    sync();
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid_empty",     32'(empty),     32'd1);
    chk("mid_out_valid", 32'(out_valid), 32'd0);
    chk("mid_overflow",  32'(overflow),  32'd0);
    sync();

    // 6b. end-to-end with adder-style results
    e2e_on = 1;
    for (int i = 0; i < 10; i++) begin
      logic [W-1:0] a, b, y;
      a = W'($urandom);
      b = W'($urandom);
      y = a + b;
      e2e_q.push_back(y);
      in_valid  = 1'b1;
      in_data   = y;
      out_ready = 1'($urandom_range(0, 1));
      sync();
      in_valid  = 1'b0;
      out_ready = 1'b1;
      sync();
    end
    repeat (6) sync();
    out_ready = 1'b0;
    @(negedge clk);
    e2e_on = 0;
    chk("e2e_pops",     32'(e2e_pops), 32'd10);
    chk("e2e_no_drops", 32'(drop_cnt), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
